// File: rtl/or1k_icache_refill_ctrl_if.sv
// Instruction bus between the icache refill sequencer and the ibus bridge.
// The master issues word beats; the slave answers with ack/err and data.
interface or1k_icache_refill_ctrl_if #(
    parameter int AW = 32
);
    logic          req;
    logic [AW-1:0] adr;
    logic          burst;
    logic          ack;
    logic          err;
    logic [AW-1:0] dat;

    modport master (
        output req, adr, burst,
        input  ack, err, dat
    );

    modport slave (
        input  req, adr, burst,
        output ack, err, dat
    );
endinterface

// File: rtl/or1k_icache_refill_ctrl.sv
// Icache line refill sequencer: critical-word-first wrapping burst,
// each acked beat written into the icache, bus errors reported as imem_err.
module or1k_icache_refill_ctrl #(
    parameter int OPTION_OPERAND_WIDTH      = 32,
    parameter int OPTION_ICACHE_BLOCK_WIDTH = 5
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            refill_req_i,
    input  logic                            refill_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] miss_adr_i,
    or1k_icache_refill_ctrl_if.master       ibus,
    output logic [OPTION_OPERAND_WIDTH-1:0] wradr_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] wrdat_o,
    output logic                            we_o,
    output logic                            imem_err_o,
    output logic                            busy_o
);
    localparam int AW  = OPTION_OPERAND_WIDTH;
    localparam int BW  = OPTION_ICACHE_BLOCK_WIDTH;
    localparam int OFW = BW - 2;
    localparam logic [OFW-1:0] LAST = {OFW{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'b001,
        S_BURST = 3'b010,
        S_FLUSH = 3'b100
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:BW]  r_base;
    logic [OFW-1:0]  r_off;
    logic [OFW-1:0]  r_cnt;
    logic            r_abort;

    logic            w_start;
    logic            w_beat;
    logic            w_we;
    logic            w_err;
    logic            w_req;
    logic            w_burst;
    logic            w_abort;
    logic [AW-1:0]   w_adr;
    logic            w_unused;

    assign w_unused = &{1'b0, miss_adr_i[1:0]};
    assign w_adr    = {r_base, r_off, 2'b00};
    // A dropped refill_i is remembered until the outstanding beat ends.
    assign w_abort  = r_abort | ~refill_i;

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_beat      = 1'b0;
        w_we        = 1'b0;
        w_err       = 1'b0;
        w_req       = 1'b0;
        w_burst     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (refill_req_i && refill_i) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_BURST;
                end
            end
            S_BURST: begin
                w_req   = 1'b1;
                w_burst = (r_cnt != LAST);
                if (ibus.err) begin
                    w_err       = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (ibus.ack) begin
                    if (w_abort) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_we   = 1'b1;
                        w_beat = 1'b1;
                        if (r_cnt == LAST)
                            w_state_nxt = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        // The beat in flight at reset is abandoned without side effects.
        if (rst) begin
            w_we  = 1'b0;
            w_err = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_base  <= '0;
            r_off   <= '0;
            r_cnt   <= '0;
            r_abort <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_base  <= miss_adr_i[AW-1:BW];
                r_off   <= miss_adr_i[BW-1:2];
                r_cnt   <= '0;
                r_abort <= 1'b0;
            end else begin
                if (w_beat) begin
                    r_off <= r_off + 1'b1;
                    r_cnt <= r_cnt + 1'b1;
                end
                if (r_state == S_BURST && !refill_i)
                    r_abort <= 1'b1;
            end
        end
    end

    assign ibus.req   = w_req;
    assign ibus.adr   = w_adr;
    assign ibus.burst = w_burst;
    assign wradr_o    = w_adr;
    assign wrdat_o    = ibus.dat;
    assign we_o       = w_we;
    assign imem_err_o = w_err;
    assign busy_o     = (r_state != S_IDLE);
endmodule

// File: tb/tb_or1k_icache_refill_ctrl.sv
// Directed bench for the icache refill sequencer, one DUT per line size
// (32-byte and 16-byte lines).
module tb_or1k_icache_refill_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic        rst_a, a_refill_req, a_refill;
    logic [31:0] a_miss, a_wradr, a_wrdat;
    logic        a_we, a_ierr, a_busy;
    logic        rst_b, b_refill_req, b_refill;
    logic [31:0] b_miss, b_wradr, b_wrdat;
    logic        b_we, b_ierr, b_busy;

    or1k_icache_refill_ctrl_if #(.AW(32)) ifa ();
    or1k_icache_refill_ctrl_if #(.AW(32)) ifb ();

    or1k_icache_refill_ctrl #(
        .OPTION_OPERAND_WIDTH(32),
        .OPTION_ICACHE_BLOCK_WIDTH(5)
    ) u_dut_a (
        .clk(clk), .rst(rst_a),
        .refill_req_i(a_refill_req), .refill_i(a_refill),
        .miss_adr_i(a_miss), .ibus(ifa.master),
        .wradr_o(a_wradr), .wrdat_o(a_wrdat), .we_o(a_we),
        .imem_err_o(a_ierr), .busy_o(a_busy)
    );

    or1k_icache_refill_ctrl #(
        .OPTION_OPERAND_WIDTH(32),
        .OPTION_ICACHE_BLOCK_WIDTH(4)
    ) u_dut_b (
        .clk(clk), .rst(rst_b),
        .refill_req_i(b_refill_req), .refill_i(b_refill),
        .miss_adr_i(b_miss), .ibus(ifb.master),
        .wradr_o(b_wradr), .wrdat_o(b_wrdat), .we_o(b_we),
        .imem_err_o(b_ierr), .busy_o(b_busy)
    );

    int we_cnt_a = 0;
    int we_cnt_b = 0;
    always @(posedge clk) begin
        we_cnt_a <= we_cnt_a + int'(a_we);
        we_cnt_b <= we_cnt_b + int'(b_we);
    end

    logic [31:0] exp1 [8] = '{32'h1014, 32'h1018, 32'h101C, 32'h1000,
                              32'h1004, 32'h1008, 32'h100C, 32'h1010};
    logic [31:0] exp2 [4] = '{32'h2008, 32'h200C, 32'h2000, 32'h2004};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    initial begin
        int w0;
        rst_a = 1'b1; rst_b = 1'b1;
        a_refill_req = 0; a_refill = 0; a_miss = '0;
        b_refill_req = 0; b_refill = 0; b_miss = '0;
        ifa.ack = 0; ifa.err = 0; ifa.dat = '0;
        ifb.ack = 0; ifb.err = 0; ifb.dat = '0;
        repeat (3) @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;
        #1;
        chk("rst_req",   32'(ifa.req),   32'd0);
        chk("rst_burst", 32'(ifa.burst), 32'd0);
        chk("rst_adr",   ifa.adr,        32'd0);
        chk("rst_wradr", a_wradr,        32'd0);
        chk("rst_we",    32'(a_we),      32'd0);
        chk("rst_ierr",  32'(a_ierr),    32'd0);
        chk("rst_busy",  32'(a_busy),    32'd0);
        chk("rst_busy_b", 32'(b_busy),   32'd0);

        // Wrapping burst, zero wait states
        @(negedge clk);
        a_refill_req = 1; a_refill = 1; a_miss = 32'h0000_1014;
        #1;
        chk("s1_req_idle", 32'(ifa.req), 32'd0);
        w0 = we_cnt_a;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            a_refill_req = 0; ifa.ack = 1; ifa.dat = 32'hC0DE_0000 + i;
            #1;
            chk($sformatf("s1_adr%0d", i),   ifa.adr, exp1[i]);
            chk($sformatf("s1_req%0d", i),   32'(ifa.req), 32'd1);
            chk($sformatf("s1_burst%0d", i), 32'(ifa.burst), 32'(i != 7));
            chk($sformatf("s1_we%0d", i),    32'(a_we), 32'd1);
            chk($sformatf("s1_wradr%0d", i), a_wradr, exp1[i]);
            chk($sformatf("s1_wrdat%0d", i), a_wrdat, 32'hC0DE_0000 + i);
        end
        @(negedge clk);
        ifa.ack = 0; a_refill = 0;
        #1;
        chk("s1_flush_busy", 32'(a_busy), 32'd1);
        chk("s1_flush_req",  32'(ifa.req), 32'd0);
        chk("s1_flush_we",   32'(a_we), 32'd0);
        @(negedge clk);
        #1;
        chk("s1_idle_busy", 32'(a_busy), 32'd0);
        chk("s1_we_count",  32'(we_cnt_a - w0), 32'd8);

        // 16-byte line, two wait states per beat
        @(negedge clk);
        b_refill_req = 1; b_refill = 1; b_miss = 32'h2008;
        #1;
        w0 = we_cnt_b;
        for (int i = 0; i < 4; i++) begin
            for (int w = 0; w < 3; w++) begin
                @(negedge clk);
                b_refill_req = 0; ifb.ack = (w == 2); ifb.dat = 32'hB000 + i;
                #1;
                chk($sformatf("s2_adr%0d_%0d", i, w), ifb.adr, exp2[i]);
                chk($sformatf("s2_req%0d_%0d", i, w), 32'(ifb.req), 32'd1);
                chk($sformatf("s2_burst%0d_%0d", i, w), 32'(ifb.burst),
                    32'(i != 3));
                chk($sformatf("s2_we%0d_%0d", i, w), 32'(b_we), 32'(w == 2));
            end
        end
        @(negedge clk);
        ifb.ack = 0; b_refill = 0;
        #1;
        chk("s2_flush_busy", 32'(b_busy), 32'd1);
        @(negedge clk);
        #1;
        chk("s2_idle_busy", 32'(b_busy), 32'd0);
        chk("s2_we_count",  32'(we_cnt_b - w0), 32'd4);

        // Bus error on third beat; ack asserted alongside must lose
        @(negedge clk);
        a_refill_req = 1; a_refill = 1; a_miss = 32'h1000;
        #1;
        w0 = we_cnt_a;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a_refill_req = 0; ifa.ack = 1; ifa.err = (i == 2);
            #1;
            chk($sformatf("s3_we%0d", i),   32'(a_we), 32'(i < 2));
            chk($sformatf("s3_ierr%0d", i), 32'(a_ierr), 32'(i == 2));
        end
        @(negedge clk);
        ifa.ack = 0; ifa.err = 0; a_refill = 0;
        #1;
        chk("s3_req_after",  32'(ifa.req), 32'd0);
        chk("s3_busy_after", 32'(a_busy), 32'd0);
        chk("s3_ierr_after", 32'(a_ierr), 32'd0);
        chk("s3_we_count",   32'(we_cnt_a - w0), 32'd2);

        // Reset during the fifth beat
        @(negedge clk);
        a_refill_req = 1; a_refill = 1; a_miss = 32'h1000;
        #1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a_refill_req = 0; ifa.ack = 1;
            #1;
            chk($sformatf("s4_we%0d", i), 32'(a_we), 32'd1);
        end
        @(negedge clk);
        rst_a = 1;
        #1;
        chk("s4_we_in_rst", 32'(a_we), 32'd0);
        w0 = we_cnt_a;
        @(negedge clk);
        rst_a = 0;
        #1;
        chk("s4_req_after",  32'(ifa.req), 32'd0);
        chk("s4_busy_after", 32'(a_busy), 32'd0);
        repeat (3) @(negedge clk);
        ifa.ack = 0; a_refill = 0;
        #1;
        chk("s4_no_we", 32'(we_cnt_a - w0), 32'd0);

        // Back-to-back misses: FLUSH and IDLE separate the bursts
        @(negedge clk);
        a_refill_req = 1; a_refill = 1; a_miss = 32'h1000;
        #1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            a_refill_req = 0; ifa.ack = 1;
            #1;
            chk($sformatf("s5a_we%0d", i), 32'(a_we), 32'd1);
        end
        @(negedge clk);
        ifa.ack = 0; a_refill_req = 1; a_miss = 32'h3004;
        #1;
        w0 = we_cnt_a;
        chk("s5_flush_busy", 32'(a_busy), 32'd1);
        chk("s5_flush_req",  32'(ifa.req), 32'd0);
        @(negedge clk);
        #1;
        chk("s5_idle_busy", 32'(a_busy), 32'd0);
        chk("s5_idle_req",  32'(ifa.req), 32'd0);
        @(negedge clk);
        a_refill_req = 0; ifa.ack = 1;
        #1;
        chk("s5_req2",   32'(ifa.req), 32'd1);
        chk("s5_adr2",   ifa.adr, 32'h3004);
        chk("s5_burst2", 32'(ifa.burst), 32'd1);
        repeat (7) @(negedge clk);
        #1;
        chk("s5_last_adr", ifa.adr, 32'h3000);
        @(negedge clk);
        ifa.ack = 0; a_refill = 0;
        #1;
        chk("s5_we_count2", 32'(we_cnt_a - w0), 32'd8);

        // refill_i dropped while a beat is pending
        @(negedge clk);
        b_refill_req = 1; b_refill = 1; b_miss = 32'h2000;
        #1;
        w0 = we_cnt_b;
        @(negedge clk);
        b_refill_req = 0; ifb.ack = 1;
        #1;
        chk("s6_we0",  32'(b_we), 32'd1);
        chk("s6_adr0", ifb.adr, 32'h2000);
        @(negedge clk);
        ifb.ack = 0; b_refill = 0;
        #1;
        chk("s6_wait_req", 32'(ifb.req), 32'd1);
        chk("s6_wait_adr", ifb.adr, 32'h2004);
        chk("s6_wait_we",  32'(b_we), 32'd0);
        @(negedge clk);
        ifb.ack = 1;
        #1;
        chk("s6_ack_we",  32'(b_we), 32'd0);
        chk("s6_ack_req", 32'(ifb.req), 32'd1);
        @(negedge clk);
        ifb.ack = 0;
        #1;
        chk("s6_req_after",  32'(ifb.req), 32'd0);
        chk("s6_busy_after", 32'(b_busy), 32'd0);
        chk("s6_we_count",   32'(we_cnt_b - w0), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
